// File: rtl/crypto_key_vault.sv
// Multi-slot key store with per-slot sticky lock, masked provisioning readback,
// an unmasked engine key port and a one-slot-per-cycle zeroize sweep.
module crypto_key_vault #(
    parameter int KEY_W  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [KEY_W-1:0]  wr_data,
    input  logic              lock_en,
    input  logic [ADDR_W-1:0] lock_addr,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [KEY_W-1:0]  rd_data,
    output logic              rd_valid,
    input  logic [ADDR_W-1:0] eng_sel,
    output logic [KEY_W-1:0]  eng_key,
    input  logic              zeroize_req,
    output logic              busy,
    output logic [DEPTH-1:0]  slot_valid,
    output logic [DEPTH-1:0]  slot_locked,
    output logic              err
);
    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [KEY_W-1:0]  KEY_ZERO = {KEY_W{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ZERO = 1'b1
    } state_t;

    state_t             state_r, state_nx_s;
    logic [IDX_W-1:0]   idx_r;
    logic [KEY_W-1:0]   mem_r [DEPTH];
    logic [DEPTH-1:0]   valid_r, locked_r;
    logic [KEY_W-1:0]   rd_data_r, eng_key_r;
    logic               rd_valid_r, err_r;

    logic               idle_s, wr_in_s, lock_in_s, rd_in_s, eng_in_s;
    logic [IDX_W-1:0]   wr_idx_s, lock_idx_s, rd_idx_s, eng_idx_s;
    logic               wr_ok_s, lock_ok_s, rd_ok_s, err_s;
    logic [KEY_W-1:0]   rd_word_s, eng_word_s;

    // Request qualification; a zeroize request in IDLE pre-empts everything else.
    always_comb begin
        idle_s     = (state_r == ST_IDLE) && !zeroize_req;
        wr_in_s    = ({1'b0, wr_addr} < DEPTH_C);
        lock_in_s  = ({1'b0, lock_addr} < DEPTH_C);
        rd_in_s    = ({1'b0, rd_addr} < DEPTH_C);
        eng_in_s   = ({1'b0, eng_sel} < DEPTH_C);
        wr_idx_s   = wr_addr[IDX_W-1:0];
        lock_idx_s = lock_addr[IDX_W-1:0];
        rd_idx_s   = rd_addr[IDX_W-1:0];
        eng_idx_s  = eng_sel[IDX_W-1:0];
        wr_ok_s    = idle_s && wr_en && wr_in_s && !locked_r[wr_idx_s];
        lock_ok_s  = idle_s && lock_en && lock_in_s;
        rd_ok_s    = idle_s && rd_en;
        err_s      = idle_s && ((wr_en && !(wr_in_s && !locked_r[wr_idx_s])) ||
                                (lock_en && !lock_in_s));
        if (rd_in_s && valid_r[rd_idx_s] && !locked_r[rd_idx_s]) begin
            rd_word_s = mem_r[rd_idx_s];
        end else begin
            rd_word_s = KEY_ZERO;
        end
        if (eng_in_s && valid_r[eng_idx_s]) begin
            eng_word_s = mem_r[eng_idx_s];
        end else begin
            eng_word_s = KEY_ZERO;
        end
    end

    // Next-state logic: the sweep leaves ZERO after clearing the last slot.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (zeroize_req) begin
                    state_nx_s = ST_ZERO;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ZERO: begin
                if (idx_r == LAST_IDX) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_ZERO;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register and sweep index (index rests at 0 outside the sweep).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
            idx_r   <= {IDX_W{1'b0}};
        end else begin
            state_r <= state_nx_s;
            if (state_r == ST_ZERO) begin
                idx_r <= idx_r + IDX_W'(1);
            end else begin
                idx_r <= {IDX_W{1'b0}};
            end
        end
    end

    // Key storage with valid and sticky lock flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= KEY_ZERO;
            end
            valid_r  <= {DEPTH{1'b0}};
            locked_r <= {DEPTH{1'b0}};
        end else if (state_r == ST_ZERO) begin
            mem_r[idx_r]    <= KEY_ZERO;
            valid_r[idx_r]  <= 1'b0;
            locked_r[idx_r] <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                mem_r[wr_idx_s]   <= wr_data;
                valid_r[wr_idx_s] <= 1'b1;
            end
            if (lock_ok_s) begin
                locked_r[lock_idx_s] <= 1'b1;
            end
        end
    end

    // Registered outputs; the engine key is forced to zero around the sweep
    // so no stale key survives into the first idle cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_data_r  <= KEY_ZERO;
            rd_valid_r <= 1'b0;
            eng_key_r  <= KEY_ZERO;
            err_r      <= 1'b0;
        end else begin
            rd_valid_r <= rd_ok_s;
            err_r      <= err_s;
            if (rd_ok_s) begin
                rd_data_r <= rd_word_s;
            end
            if ((state_r == ST_ZERO) || (state_nx_s == ST_ZERO)) begin
                eng_key_r <= KEY_ZERO;
            end else begin
                eng_key_r <= eng_word_s;
            end
        end
    end

    assign rd_data     = rd_data_r;
    assign rd_valid    = rd_valid_r;
    assign eng_key     = eng_key_r;
    assign err         = err_r;
    assign busy        = (state_r == ST_ZERO);
    assign slot_valid  = valid_r;
    assign slot_locked = locked_r;
endmodule

// File: tb/tb_crypto_key_vault.sv
// Bench for crypto_key_vault: directed vector table, hand sequences for the
// zeroize sweep and mid-sweep reset, and randomized traffic against a model.
module tb_crypto_key_vault;
    localparam int KEY_W  = 16;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              resetn;
    logic              wr_en, lock_en, rd_en, zeroize_req;
    logic [ADDR_W-1:0] wr_addr, lock_addr, rd_addr, eng_sel;
    logic [KEY_W-1:0]  wr_data;
    logic [KEY_W-1:0]  rd_data, eng_key;
    logic              rd_valid, busy, err;
    logic [DEPTH-1:0]  slot_valid, slot_locked;

    always #5 clk = ~clk;

    crypto_key_vault #(.KEY_W(KEY_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .resetn(resetn),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .lock_en(lock_en), .lock_addr(lock_addr),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .eng_sel(eng_sel), .eng_key(eng_key),
        .zeroize_req(zeroize_req), .busy(busy),
        .slot_valid(slot_valid), .slot_locked(slot_locked), .err(err)
    );

    // Reference model: key table plus a count of sweep cycles still to run.
    bit [KEY_W-1:0] m_data [DEPTH];
    bit [DEPTH-1:0] m_valid, m_locked;
    int             m_zleft;
    bit [KEY_W-1:0] m_rdd, m_eng;
    bit             m_rdv, m_err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] wa;
        logic [KEY_W-1:0]  wd;
        logic              lk;
        logic [ADDR_W-1:0] la;
        logic              rd;
        logic [ADDR_W-1:0] ra;
        logic [ADDR_W-1:0] es;
        logic              zr;
        logic              e_rdv;
        logic [KEY_W-1:0]  e_rdd;
        logic              e_err;
        logic [KEY_W-1:0]  e_eng;
    } vec_t;
    vec_t vecs [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_data[i] = '0;
        m_valid = '0; m_locked = '0; m_zleft = 0;
        m_rdd = '0; m_eng = '0; m_rdv = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_edge();
        int  k, wa, la, ra, es;
        bit  wr_bad;
        if (m_zleft > 0) begin
            k = DEPTH - m_zleft;
            m_data[k] = '0; m_valid[k] = 1'b0; m_locked[k] = 1'b0;
            m_zleft--;
            m_rdv = 1'b0; m_err = 1'b0; m_eng = '0;
        end else if (zeroize_req) begin
            m_zleft = DEPTH;
            m_rdv = 1'b0; m_err = 1'b0; m_eng = '0;
        end else begin
            wa = int'(wr_addr); la = int'(lock_addr); ra = int'(rd_addr); es = int'(eng_sel);
            wr_bad = wr_en && ((wa >= DEPTH) ? 1'b1 : m_locked[wa]);
            m_err  = wr_bad || (lock_en && la >= DEPTH);
            m_rdv  = rd_en;
            if (rd_en) begin
                if (ra < DEPTH && m_valid[ra] && !m_locked[ra]) m_rdd = m_data[ra];
                else m_rdd = '0;
            end
            if (es < DEPTH && m_valid[es]) m_eng = m_data[es];
            else m_eng = '0;
            if (wr_en && !wr_bad) begin
                m_data[wa] = wr_data; m_valid[wa] = 1'b1;
            end
            if (lock_en && la < DEPTH) m_locked[la] = 1'b1;
        end
    endtask

    task automatic check_outputs();
        check("rd_valid", rd_valid, m_rdv);
        check("rd_data", rd_data, m_rdd);
        check("eng_key", eng_key, m_eng);
        check("err", err, m_err);
        check("busy", busy, m_zleft > 0);
        check("slot_valid", slot_valid, m_valid);
        check("slot_locked", slot_locked, m_locked);
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        lock_en = 1'b0; lock_addr = '0;
        rd_en = 1'b0; rd_addr = '0; eng_sel = '0; zeroize_req = 1'b0;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        #2;
        resetn = 1'b0;
        #1;
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_eng_key", eng_key, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_slot_valid", slot_valid, 0);
        check("rst_slot_locked", slot_locked, 0);
        model_reset();
        idle_inputs();
        @(posedge clk);
        #2;
        resetn = 1'b1;
    endtask

    // Hammers every request while busy; returns how many cycles busy was seen high.
    task automatic run_sweep(output int cnt);
        cnt = 0;
        for (int c = 0; c < 40 && busy; c++) begin
            cnt++;
            wr_en = 1'b1; wr_addr = ADDR_W'($urandom_range(0, 9)); wr_data = KEY_W'($urandom);
            lock_en = 1'b1; lock_addr = ADDR_W'($urandom_range(0, 12));
            rd_en = 1'b1; rd_addr = ADDR_W'($urandom_range(0, 7));
            zeroize_req = 1'b1;
            step();
        end
        idle_inputs();
    endtask

    initial begin
        int cnt;
        vecs[0]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0,  1'b1, 4'd3,  4'd0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000};
        vecs[1]  = '{1'b1, 4'd3, 16'hA5C3, 1'b0, 4'd0,  1'b0, 4'd0,  4'd3, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vecs[2]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0,  1'b1, 4'd3,  4'd3, 1'b0, 1'b1, 16'hA5C3, 1'b0, 16'hA5C3};
        vecs[3]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd3,  1'b0, 4'd0,  4'd3, 1'b0, 1'b0, 16'hA5C3, 1'b0, 16'hA5C3};
        vecs[4]  = '{1'b1, 4'd3, 16'h1111, 1'b0, 4'd0,  1'b0, 4'd0,  4'd3, 1'b0, 1'b0, 16'hA5C3, 1'b1, 16'hA5C3};
        vecs[5]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0,  1'b1, 4'd3,  4'd3, 1'b0, 1'b1, 16'h0000, 1'b0, 16'hA5C3};
        vecs[6]  = '{1'b1, 4'd9, 16'h1234, 1'b1, 4'd12, 1'b0, 4'd0,  4'd3, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hA5C3};
        vecs[7]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0,  1'b1, 4'd10, 4'd3, 1'b0, 1'b1, 16'h0000, 1'b0, 16'hA5C3};
        vecs[8]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd3,  1'b0, 4'd0,  4'd9, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vecs[9]  = '{1'b1, 4'd2, 16'hBEEF, 1'b1, 4'd2,  1'b0, 4'd0,  4'd2, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vecs[10] = '{1'b1, 4'd2, 16'h0000, 1'b0, 4'd0,  1'b0, 4'd0,  4'd2, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hBEEF};
        vecs[11] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0,  1'b1, 4'd2,  4'd2, 1'b0, 1'b1, 16'h0000, 1'b0, 16'hBEEF};
        vecs[12] = '{1'b1, 4'd3, 16'h7777, 1'b0, 4'd0,  1'b1, 4'd3,  4'd2, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};

        resetn = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        resetn = 1'b1;

        // Every slot reads back as zero after reset.
        for (int s = 0; s < DEPTH; s++) begin
            rd_en = 1'b1; rd_addr = ADDR_W'(s);
            step();
            check("post_rst_rdv", rd_valid, 1);
            check("post_rst_rdd", rd_data, 0);
        end
        idle_inputs();
        step();

        for (int i = 0; i < 13; i++) begin
            wr_en = vecs[i].wr; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            lock_en = vecs[i].lk; lock_addr = vecs[i].la;
            rd_en = vecs[i].rd; rd_addr = vecs[i].ra;
            eng_sel = vecs[i].es; zeroize_req = vecs[i].zr;
            step();
            check($sformatf("vec%0d_rd_valid", i), rd_valid, vecs[i].e_rdv);
            check($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].e_rdd);
            check($sformatf("vec%0d_err", i), err, vecs[i].e_err);
            check($sformatf("vec%0d_eng_key", i), eng_key, vecs[i].e_eng);
            if (i == 2) check("slot_valid_after_w3", slot_valid, 8'h08);
            if (i == 11) check("locked_2_and_3", slot_locked, 8'h0C);
        end
        run_sweep(cnt);
        check("busy_len_a", cnt, DEPTH);
        check("sweep_a_valid", slot_valid, 0);
        check("sweep_a_locked", slot_locked, 0);
        step();

        // Fill every slot, lock one, then sweep and confirm everything reads zero.
        for (int s = 0; s < DEPTH; s++) begin
            wr_en = 1'b1; wr_addr = ADDR_W'(s); wr_data = KEY_W'($urandom);
            step();
        end
        idle_inputs();
        lock_en = 1'b1; lock_addr = 4'd5;
        step();
        check("full_before_sweep", slot_valid, 8'hFF);
        idle_inputs();
        zeroize_req = 1'b1;
        step();
        run_sweep(cnt);
        check("busy_len_b", cnt, DEPTH);
        check("sweep_b_valid", slot_valid, 0);
        check("sweep_b_locked", slot_locked, 0);
        for (int s = 0; s < DEPTH; s++) begin
            rd_en = 1'b1; rd_addr = ADDR_W'(s); eng_sel = ADDR_W'(s);
            step();
            check("sweep_b_rdd", rd_data, 0);
            check("sweep_b_eng", eng_key, 0);
        end
        idle_inputs();

        // Reset dropped on the fourth sweep cycle.
        wr_en = 1'b1; wr_addr = 4'd6; wr_data = 16'hCAFE;
        step();
        idle_inputs();
        zeroize_req = 1'b1;
        step();
        idle_inputs();
        repeat (3) step();
        check("busy_before_rst", busy, 1);
        do_reset();
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'h5A5A;
        step();
        idle_inputs();
        rd_en = 1'b1; rd_addr = 4'd4;
        step();
        check("after_rst_rdd", rd_data, 16'h5A5A);
        check("after_rst_valid", slot_valid, 8'h10);
        idle_inputs();

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            wr_en = 1'($urandom_range(0, 1)); wr_addr = ADDR_W'($urandom_range(0, 9));
            wr_data = KEY_W'($urandom);
            lock_en = ($urandom_range(0, 5) == 0); lock_addr = ADDR_W'($urandom_range(0, 9));
            rd_en = 1'($urandom_range(0, 1)); rd_addr = ADDR_W'($urandom_range(0, 9));
            eng_sel = ADDR_W'($urandom_range(0, 9));
            zeroize_req = ($urandom_range(0, 24) == 0);
            step();
        end
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/crypto_key_vault.md
Name: crypto_key_vault

Overview:
Multi-slot, parametrised key store holding DEPTH keys of KEY_W bits each, with deterministic reset clearing, per-slot sticky write/read lock, and a sequenced zeroize sweep. It sits between the key-provisioning bus (write/lock/readback) and the crypto engine (engine key port). Storage never holds or exposes an uninitialised value.

Parameters:
KEY_W, 16, key width in bits (>=1)
DEPTH, 8, number of key slots (>=2)
ADDR_W, 3, slot address width; DEPTH <= 2**ADDR_W

Ports:
clk  input  1  rising-edge clock
resetn  input  1  asynchronous active-low reset
wr_en  input  1  write request
wr_addr  input  ADDR_W  write slot
wr_data  input  KEY_W  write data
lock_en  input  1  lock request
lock_addr  input  ADDR_W  slot to lock
rd_en  input  1  provisioning readback request
rd_addr  input  ADDR_W  readback slot
rd_data  output  KEY_W  readback data (registered)
rd_valid  output  1  readback data valid, 1-cycle pulse
eng_sel  input  ADDR_W  engine key select
eng_key  output  KEY_W  engine key (registered)
zeroize_req  input  1  start zeroize sweep
busy  output  1  zeroize in progress
slot_valid  output  DEPTH  per-slot written flag
slot_locked  output  DEPTH  per-slot lock flag
err  output  1  1-cycle pulse on rejected write/lock

Behaviour:
- Reset (resetn low, async): all slot data = 0, slot_valid = 0, slot_locked = 0, rd_data = 0, rd_valid = 0, eng_key = 0, busy = 0, err = 0, FSM = IDLE. Reset mid-sweep aborts sweep; all state cleared regardless.
- FSM states: IDLE, ZERO. IDLE -> ZERO on zeroize_req (sweep index = 0). ZERO: clear slot[index] data, valid, lock; index increments each cycle; after clearing slot DEPTH-1 -> IDLE. busy = 1 for exactly DEPTH cycles, starting the cycle after zeroize_req is sampled.
- Write (IDLE only): wr_en with wr_addr < DEPTH and slot unlocked -> slot <= wr_data, slot_valid[addr] <= 1 at next edge. Locked slot or wr_addr >= DEPTH -> no change, err = 1 next cycle.
- Lock (IDLE only): lock_en sets slot_locked[lock_addr]; sticky until zeroize or reset. lock_addr >= DEPTH -> err. Lock on an already-locked slot: no error, no change.
- Same-cycle write + lock to same unlocked slot: write is applied, lock takes effect from next cycle.
- Readback: rd_en sampled -> next cycle rd_valid = 1, rd_data = slot data if slot_valid and not slot_locked, else 0. Out-of-range rd_addr -> rd_data 0, rd_valid 1. rd_data holds value until next read; rd_valid is a single-cycle pulse.
- Engine port: eng_key registered each cycle = slot[eng_sel] if slot_valid, else 0 (lock does not mask engine path); out-of-range -> 0. Latency 1 cycle. During ZERO, eng_key = 0.
- While busy: wr_en, lock_en, rd_en, zeroize_req ignored, no err; rd_valid stays 0.
- Same-cycle zeroize_req with wr_en/lock_en/rd_en in IDLE: zeroize wins; other requests dropped, no err.
- err is a 1-cycle pulse; simultaneous rejected write and lock produce one pulse.

Test Plan:
- Reset check: assert resetn=0 mid-cycle -> all outputs 0 immediately; after release, read each slot -> rd_data=0, rd_valid=1 one cycle after rd_en.
- Write slot 3 = 0xA5C3, read slot 3 -> rd_data=0xA5C3 one cycle later; slot_valid=8'h08; eng_sel=3 -> eng_key=0xA5C3.
- Lock slot 3, write 0x1111 to slot 3 -> err pulse, data unchanged; readback slot 3 -> 0; eng_key still 0xA5C3.
- Write slots 0..7, lock slot 5, zeroize_req -> busy high exactly 8 cycles; writes during busy ignored; after sweep slot_valid=0, slot_locked=0, all reads 0.
- Same-cycle write 0xBEEF + lock on slot 2 -> slot 2 holds 0xBEEF, locked; subsequent write rejected with err.
- Drop resetn at sweep cycle 4 -> immediate clear, busy=0; after release FSM IDLE and write/read work normally.
